// File: rtl/gate_test_if.sv
// Bundles the sequencer's control/status handshake and the gate-under-test
// connection. master = lab top level / gate side, slave = the sequencer.
interface gate_test_if #(
  parameter int NUM_INPUTS = 2
);
  logic                  start;
  logic                  dut_y;
  logic [NUM_INPUTS-1:0] vec;
  logic                  busy;
  logic                  chk_strobe;
  logic                  chk_ok;
  logic                  done;
  logic                  pass;
  logic [NUM_INPUTS:0]   err_count;
  logic                  first_fail_valid;
  logic [NUM_INPUTS-1:0] first_fail_vec;

  modport master (
    output start, dut_y,
    input  vec, busy, chk_strobe, chk_ok, done, pass,
           err_count, first_fail_valid, first_fail_vec
  );

  modport slave (
    input  start, dut_y,
    output vec, busy, chk_strobe, chk_ok, done, pass,
           err_count, first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Exhaustive self-test sequencer for a small combinational gate. Walks every
// input vector, holds it for SETTLE_CYCLES, samples the gate output for one
// CHECK cycle and compares it against the EXPECTED truth table.
module gate_test_sequencer #(
  parameter int                            NUM_INPUTS    = 2,
  parameter int                            SETTLE_CYCLES = 2,
  parameter logic [(1<<NUM_INPUTS)-1:0]    EXPECTED      = 4'b1000
) (
  input logic       clk,
  input logic       rst,
  gate_test_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  // Counter must be able to hold SETTLE_CYCLES itself.
  localparam int                    CW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [NUM_INPUTS-1:0] LAST_VEC    = NUM_INPUTS'((1 << NUM_INPUTS) - 1);
  localparam logic [CW-1:0]         SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [NUM_INPUTS-1:0] vec_q, vec_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_INPUTS:0]   err_q, err_d;
  logic                  ffv_q, ffv_d;
  logic [NUM_INPUTS-1:0] ffvec_q, ffvec_d;
  logic                  busy_q, busy_d;
  logic                  strobe_q, strobe_d;
  logic                  done_q, done_d;
  logic                  mismatch;

  // Gate output disagrees with the truth table for the vector being driven.
  assign mismatch = (bus.dut_y != EXPECTED[vec_q]);

  // Next-state and next-datapath logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      end

      S_CHECK: begin
        // err_count is N+1 bits wide and at most 2^N vectors are checked, so it never wraps.
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they come straight off flops.
  assign busy_d   = (state_d == S_SETTLE) || (state_d == S_CHECK);
  assign strobe_d = (state_d == S_CHECK);
  assign done_d   = (state_d == S_DONE);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign bus.vec              = vec_q;
  assign bus.busy             = busy_q;
  assign bus.chk_strobe       = strobe_q;
  // Only outputs with a combinational term: chk_ok (live dut_y) and pass.
  assign bus.chk_ok           = strobe_q & ~mismatch;
  assign bus.done             = done_q;
  assign bus.pass             = done_q & (err_q == '0);
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomized self-checking bench. Two sequencers run side by side: one with the
// default AND truth table and one with EXPECTED=4'b1110 (OR). Each is wired to a
// behavioural "gate" given by a TB truth table; the reference model predicts
// every cycle of a run from the start edge using plain arithmetic.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] gtt_a = 4'b1000;
  logic [3:0] gtt_b = 4'b1110;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [3:0] EXP_A = 4'b1000;
  localparam logic [3:0] EXP_B = 4'b1110;

  always #5 clk = ~clk;

  gate_test_if #(.NUM_INPUTS(2)) if_a ();
  gate_test_if #(.NUM_INPUTS(2)) if_b ();

  assign if_a.dut_y = gtt_a[if_a.vec];
  assign if_b.dut_y = gtt_b[if_b.vec];

  gate_test_sequencer u_and (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  gate_test_sequencer #(
    .NUM_INPUTS    (2),
    .SETTLE_CYCLES (2),
    .EXPECTED      (4'b1110)
  ) u_or (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: cycle t counts from 0 on the first cycle after the start edge.
  // Each vector lasts 3 cycles (2 settle + 1 check); vector v is checked in cycle 3v+2.
  task automatic check_cycle(input string who, input int t, input logic [3:0] gtt,
                             input logic [3:0] exp, input logic [1:0] vec,
                             input logic busy, input logic strobe, input logic ok,
                             input logic done, input logic pass, input logic [2:0] err,
                             input logic ffv, input logic [1:0] ffvec);
    int  e_vec, e_err, e_ff;
    bit  e_ffv, in_run;
    string p;
    in_run = (t < 12);
    e_vec  = in_run ? t / 3 : 3;
    e_err  = 0;
    e_ffv  = 0;
    e_ff   = 0;
    for (int v = 0; v < 4; v++) begin
      if ((3 * v + 2 < t) && (gtt[v] != exp[v])) begin
        e_err++;
        if (!e_ffv) begin
          e_ffv = 1;
          e_ff  = v;
        end
      end
    end
    p = $sformatf("%s t=%0d", who, t);
    check({p, " vec"},    vec,    e_vec);
    check({p, " busy"},   busy,   in_run);
    check({p, " strobe"}, strobe, in_run && (t % 3 == 2));
    check({p, " done"},   done,   !in_run);
    check({p, " err"},    err,    e_err);
    check({p, " ffv"},    ffv,    e_ffv);
    check({p, " ffvec"},  ffvec,  e_ff);
    if (in_run && (t % 3 == 2))
      check({p, " chk_ok"}, ok, gtt[e_vec] == exp[e_vec]);
    if (!in_run)
      check({p, " pass"}, pass, e_err == 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " a vec"},  if_a.vec, 0);
    check({tag, " a stat"}, {if_a.busy, if_a.chk_strobe, if_a.chk_ok, if_a.done, if_a.pass,
                             if_a.first_fail_valid}, 0);
    check({tag, " a err"},  if_a.err_count, 0);
    check({tag, " a ff"},   if_a.first_fail_vec, 0);
    check({tag, " b vec"},  if_b.vec, 0);
    check({tag, " b stat"}, {if_b.busy, if_b.chk_strobe, if_b.chk_ok, if_b.done, if_b.pass,
                             if_b.first_fail_valid}, 0);
    check({tag, " b err"},  if_b.err_count, 0);
    check({tag, " b ff"},   if_b.first_fail_vec, 0);
  endtask

  // One run on both sequencers. repulse_t / rst_t >= 0 raise start / rst during
  // cycle t so it is sampled on the following edge.
  task automatic run(input logic [3:0] ga, input logic [3:0] gb,
                     input int repulse_t, input int rst_t);
    @(negedge clk);
    gtt_a = ga;
    gtt_b = gb;
    if_a.start = 1'b1;
    if_b.start = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 14; t++) begin
      if (t > 0) @(negedge clk);
      check_cycle("and", t, gtt_a, EXP_A, if_a.vec, if_a.busy, if_a.chk_strobe, if_a.chk_ok,
                  if_a.done, if_a.pass, if_a.err_count, if_a.first_fail_valid,
                  if_a.first_fail_vec);
      check_cycle("or", t, gtt_b, EXP_B, if_b.vec, if_b.busy, if_b.chk_strobe, if_b.chk_ok,
                  if_b.done, if_b.pass, if_b.err_count, if_b.first_fail_valid,
                  if_b.first_fail_vec);
      if_a.start = (t == repulse_t);
      if_b.start = (t == repulse_t);
      if (t == rst_t) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        check_idle("after rst");
        @(negedge clk);
        check_idle("idle hold");
        return;
      end
    end
    if_a.start = 1'b0;
    if_b.start = 1'b0;
  endtask

  initial begin
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle");

    run(4'b1000, 4'b1110, -1, -1);  // correct AND / correct OR
    run(4'b0000, 4'b1000, -1, -1);  // stuck-at-0 / AND against OR table
    run(4'b1111, 4'b1111, -1, -1);  // stuck-at-1 on both
    run(4'b1000, 4'b1110,  3, -1);  // restart from failing DONE; start re-pulsed in SETTLE of vec 1
    run(4'b1000, 4'b1110, -1,  7);  // reset while vec=2
    run(4'b1000, 4'b1110, -1, -1);  // clean run after reset

    for (int i = 0; i < 24; i++) begin
      logic [3:0] ga, gb;
      int rp, rs;
      ga = 4'($urandom_range(0, 15));
      gb = 4'($urandom_range(0, 15));
      rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 11)) : -1;
      rs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 11)) : -1;
      run(ga, gb, rp, rs);
    end

    // Results must stay put in DONE with no start.
    repeat (3) @(negedge clk);
    check("hold a done", if_a.done, 1);
    check("hold b done", if_b.done, 1);
    check("hold a vec",  if_a.vec, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
- On-chip controller that exhaustively exercises a small combinational gate (the lab's 2-input AND by default) and self-checks it.
- Steps through every input vector, holds each vector for a settle window, samples the gate output, and compares it with a parameterised truth table.
- Reports pass/fail, error count and first failing vector.
- Sits between the lab top level (start button / LEDs) and the gate under test.

Parameters:
- NUM_INPUTS, 2, number of gate inputs N; 2^N vectors are applied; legal range 1..6.
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; minimum 1.
- EXPECTED, 4'b1000, truth table of width 2^N; bit i is the required output for input vector i. The default is AND.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE or DONE.
- dut_y  in  1  output of the gate under test.
- vec  out  N  input vector driven to the gate under test; bit 0 drives input A, bit 1 drives input B.
- busy  out  1  high while a run is in progress (SETTLE or CHECK).
- chk_strobe  out  1  one-cycle pulse when a vector is checked.
- chk_ok  out  1  valid with chk_strobe; 1 when dut_y equals EXPECTED[vec].
- done  out  1  high in DONE; results are stable.
- pass  out  1  valid when done is high; 1 when err_count is 0.
- err_count  out  N+1  number of mismatching vectors in the last run.
- first_fail_valid  out  1  high once any mismatch has occurred in the current run.
- first_fail_vec  out  N  vector of the first mismatch; 0 when first_fail_valid is 0.

Behaviour:
- Reset (synchronous, active-high), applied at any time including mid-run:
  - state is IDLE.
  - vec, err_count, first_fail_vec and the settle counter are 0.
  - busy, chk_strobe, chk_ok, done, pass and first_fail_valid are 0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - vec is 0 and all status outputs are 0.
  - start=1 moves to SETTLE.
  - On that same edge: vec=0, settle counter=0, err_count=0, first_fail_valid=0, first_fail_vec=0.
- SETTLE:
  - busy=1; vec is held.
  - The settle counter increments every cycle.
  - After SETTLE_CYCLES cycles in SETTLE, move to CHECK.
- CHECK (exactly 1 cycle):
  - busy=1, chk_strobe=1, chk_ok = (dut_y == EXPECTED[vec]); dut_y is sampled in this cycle.
  - On mismatch: err_count increments by 1 (it cannot overflow, max 2^N). If first_fail_valid is 0, first_fail_vec=vec and first_fail_valid=1.
  - If vec == 2^N-1: move to DONE; vec holds its last value.
  - Otherwise: vec increments by 1, the settle counter clears, and the state returns to SETTLE.
- DONE:
  - done=1, busy=0, pass=(err_count==0); results are held.
  - start=1 restarts exactly as from IDLE (counters cleared on that edge).
- start is ignored in SETTLE and CHECK; there is no queuing.
- Timing: if start is sampled at edge k, vec=0 is valid from cycle k+1.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done rises after edge k + 2^N*(SETTLE_CYCLES+1), i.e. 12 cycles with default parameters.
- vec changes only on leaving CHECK (or on reset/start). The gate therefore sees stable inputs for at least SETTLE_CYCLES cycles before sampling.
- No combinational path from dut_y to any output except chk_ok.
- All outputs other than chk_ok and pass are registered.

Test Plan:
- Defaults, correct AND gate wired to vec; pulse start:
  - vec steps 0,1,2,3, each held 3 cycles.
  - chk_ok=1 on all 4 strobes.
  - done after 12 cycles, pass=1, err_count=0, first_fail_valid=0.
- dut_y stuck at 0:
  - one mismatch (vector 3); err_count=1, pass=0, first_fail_vec=3, first_fail_valid=1.
- dut_y stuck at 1:
  - err_count=3, first_fail_vec=0; chk_ok pattern 0,0,0,1.
- start re-pulsed during SETTLE of vector 1:
  - ignored; the run completes normally at the original 12-cycle point.
- rst asserted for one cycle while vec=2:
  - next cycle is IDLE with all outputs 0.
  - A subsequent start gives a clean full run with correct results.
- From DONE after a failing run, pulse start with a correct gate:
  - counters clear on the start edge; the run ends pass=1, err_count=0.
- EXPECTED=4'b1110 with an OR gate:
  - pass=1.
- EXPECTED=4'b1110 with the AND gate:
  - err_count=2, first_fail_vec=1.
